multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
//  Multi-cycle main control FSM; upstream producer of the 2-bit ALUOp code consumed by the ALU control unit.
//  Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables.
//  Runs a req/ack handshake with the unified instruction/data memory port and counts retired instructions.
//  Supported: R-type (0110011), LW (0000011), SW (0100011), BEQ (1100011); any other opcode traps.
// PARAMETERS
//  CNT_W       32  width of retired-instruction counter
//  OPCODE_W     7  opcode field width, Inst[6:0]
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  Inst         in   32  instruction register contents (valid from DECODE onward)
//  Zero         in   1   ALU zero flag
//  mem_ack      in   1   memory completes current request this cycle
//  mem_req      out  1   memory request (held until mem_ack)
//  MemRead      out  1   request is a read (fetch or load)
//  MemWrite     out  1   request is a write (store)
//  IorD         out  1   0: address=PC, 1: address=ALUOut
//  IRWrite      out  1   load IR and OldPC from memory data
//  PCWrite      out  1   unconditional PC update
//  PCWriteCond  out  1   PC update gated by Zero (branch)
//  ALUSrcA      out  1   0: PC/OldPC, 1: rs1
//  ALUSrcB      out  2   00: rs2, 01: const 4, 10: imm
//  ALUOp        out  2   00 add, 01 sub, 10 decode funct3/funct7
//  RegWrite     out  1   register file write enable
//  MemtoReg     out  1   0: ALUOut, 1: MDR
//  trap         out  1   illegal opcode seen; sticky
//  retired      out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=START, retired=0, all outputs 0; mem_req drops same cycle.
//  - Moore outputs decoded from state register; ALUOp 00 unless listed.
//  - START: 1 cycle, all outputs 0 -> FETCH.
//  - FETCH: mem_req=MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01; IRWrite=PCWrite=1 only in mem_ack cycle.
//      mem_ack=0 -> stay; mem_ack=1 -> DECODE. Ack in same cycle req first asserted is accepted.
//  - DECODE: ALUSrcA=0(OldPC), ALUSrcB=10 (branch target into ALUOut); by Inst[6:0]:
//      R->EXEC_R, LW/SW->EXEC_ADDR, BEQ->EXEC_BR, else->TRAP.
//  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R.
//  - EXEC_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD (LW) or MEM_WR (SW).
//  - EXEC_BR: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 -> FETCH; retire.
//  - MEM_RD: mem_req=MemRead=1, IorD=1; wait for mem_ack -> WB_MEM.
//  - MEM_WR: mem_req=MemWrite=1, IorD=1; wait for mem_ack -> FETCH; retire.
//  - WB_R: RegWrite=1, MemtoReg=0 -> FETCH; retire.  WB_MEM: RegWrite=1, MemtoReg=1 -> FETCH; retire.
//  - TRAP: trap=1, all other outputs 0, no exit except reset; retired frozen.
//  - retire = retired+1 on the state's last cycle; wraps modulo 2^CNT_W, no saturation.
//  - mem_ack while mem_req=0 ignored. mem_req never deasserts before ack (no abort except reset).
//  - Latency (ack same cycle): BEQ 3, R/SW 4, LW 5 cycles; each stall cycle adds 1.
// STRUCTURE
//  - Package riscv_ctrl_pkg: opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ), ALUOp encodings
//    (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), ALUSrcB encodings, 4-bit state enum.
//  - Sub-module opcode_class_decoder: combinational Inst[6:0] -> {is_r,is_lw,is_sw,is_beq,illegal}.
//  - Top: state register + next-state logic, output decode, retired counter.
// TESTING
//  - Reset then R-type add (0x002081B3), ack immediate -> states START,FETCH,DECODE,EXEC_R,WB_R; ALUOp=10 in EXEC_R; retired=1.
//  - LW 0x0000A103 with mem_ack delayed 3 cycles in both FETCH and MEM_RD -> mem_req held, 11 cycles fetch-to-FETCH, RegWrite+MemtoReg=1 once.
//  - BEQ 0x00208463, Zero=1 then Zero=0 -> PCWriteCond=1, ALUOp=01 in EXEC_BR both times; 3 cycles each; retired +2.
//  - Illegal opcode 0x0000007F -> TRAP after DECODE, trap=1 sticky for 20 cycles, mem_req=0, retired unchanged.
//  - rst_n low mid MEM_WR while mem_req=1 -> mem_req/MemWrite drop same cycle, retired=0, restart at START.
//  - Preload retired=0xFFFFFFFF (force), retire one SW -> retired=0x00000000; stray mem_ack in DECODE ignored.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control: opcodes, ALU
// selector codes, FSM state enum and the opcode class bundle.
package riscv_ctrl_pkg;

    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_ADDR, S_EXEC_BR,
        S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_MEM, S_TRAP
    } state_t;

    typedef struct packed {
        logic is_r;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decoder.sv
// Classifies the opcode field into the four supported instruction classes;
// anything else is flagged illegal.
import riscv_ctrl_pkg::*;

module opcode_class_decoder #(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           cls
);

    always_comb begin
        cls         = '0;
        cls.is_r    = (opcode == OP_R);
        cls.is_lw   = (opcode == OP_LW);
        cls.is_sw   = (opcode == OP_SW);
        cls.is_beq  = (opcode == OP_BEQ);
        cls.illegal = !(cls.is_r || cls.is_lw || cls.is_sw || cls.is_beq);
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and counts retired instructions.
import riscv_ctrl_pkg::*;

module multicycle_main_control #(
    parameter int CNT_W    = 32,
    parameter int OPCODE_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Inst,
    input  logic             Zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_t           state, state_nxt;
    op_class_t        cls;
    logic             retire;
    logic [CNT_W-1:0] retired_q;

    // Zero gates PCWriteCond in the datapath; the upper Inst bits belong to ALU control.
    logic unused_in;
    assign unused_in = Zero ^ (^Inst[31:OPCODE_W]);

    opcode_class_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
        .opcode (Inst[OPCODE_W-1:0]),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_START;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        mem_req     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        trap        = 1'b0;
        unique case (state)
            S_START: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR and PC only latch when the memory data is actually present.
                IRWrite = mem_ack;
                PCWrite = mem_ack;
                if (mem_ack) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM;
                if (cls.is_r)                   state_nxt = S_EXEC_R;
                else if (cls.is_lw || cls.is_sw) state_nxt = S_EXEC_ADDR;
                else if (cls.is_beq)             state_nxt = S_EXEC_BR;
                else                             state_nxt = S_TRAP;
            end
            S_EXEC_R: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_FUNCT;
                state_nxt = S_WB_R;
            end
            S_EXEC_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = cls.is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_EXEC_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                retire      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ack) state_nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ack;
                if (mem_ack) state_nxt = S_FETCH;
            end
            S_WB_R: begin
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_WB_MEM: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_q <= '0;
        else if (retire) retired_q <= retired_q + 1'b1;
    end

    assign retired = retired_q;

endmodule
